// File: rtl/regfile_write_buffer.sv
// rtl/regfile_write_buffer.sv - in-order write buffer feeding the register file write port
// Queues register writes, drains one per cycle unless held, and forwards queued data to two readers.
module regfile_write_buffer #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [ADDR_WIDTH-1:0] InRegister,
  input  logic [DATA_WIDTH-1:0] InData,
  input  logic                  Hold,
  output logic [ADDR_WIDTH-1:0] WriteRegister,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] LookupRegister1,
  input  logic [ADDR_WIDTH-1:0] LookupRegister2,
  output logic                  FwdHit1,
  output logic [DATA_WIDTH-1:0] FwdData1,
  output logic                  FwdHit2,
  output logic [DATA_WIDTH-1:0] FwdData2,
  output logic [CNT_W-1:0]      Count
);

  logic [ADDR_WIDTH-1:0] r_reg  [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]      r_valid;
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [PTR_W-1:0]      w_idx;

  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign InReady  = !w_full && !Reset;
  // Writes to register 0 complete the handshake but are dropped here.
  assign w_push   = InValid && InReady && (InRegister != '0);
  assign RegWrite = !w_empty && !Hold && !Reset;
  assign w_pop    = RegWrite;
  assign Count    = r_count;

  assign WriteRegister = w_empty ? '0 : r_reg[r_head];
  assign WriteData     = w_empty ? '0 : r_data[r_head];

  // Walk oldest to youngest so the youngest match overrides older ones.
  always_comb begin
    FwdHit1  = 1'b0;
    FwdData1 = '0;
    FwdHit2  = 1'b0;
    FwdData2 = '0;
    w_idx    = r_head;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PTR_W'(i);
      if (!Reset && r_valid[w_idx] && (LookupRegister1 != '0) &&
          (r_reg[w_idx] == LookupRegister1)) begin
        FwdHit1  = 1'b1;
        FwdData1 = r_data[w_idx];
      end
      if (!Reset && r_valid[w_idx] && (LookupRegister2 != '0) &&
          (r_reg[w_idx] == LookupRegister2)) begin
        FwdHit2  = 1'b1;
        FwdData2 = r_data[w_idx];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_push) begin
        r_reg[r_tail]   <= InRegister;
        r_data[r_tail]  <= InData;
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_buffer.sv
// tb/tb_regfile_write_buffer.sv - directed vector bench for regfile_write_buffer
module tb_regfile_write_buffer;

  logic        Clk = 1'b0;
  logic        Reset, InValid, Hold;
  logic        InReady, RegWrite, FwdHit1, FwdHit2;
  logic [4:0]  InRegister, WriteRegister, LookupRegister1, LookupRegister2;
  logic [31:0] InData, WriteData, FwdData1, FwdData2;
  logic [2:0]  Count;

  regfile_write_buffer dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .InRegister(InRegister), .InData(InData), .Hold(Hold),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .LookupRegister1(LookupRegister1), .LookupRegister2(LookupRegister2),
    .FwdHit1(FwdHit1), .FwdData1(FwdData1), .FwdHit2(FwdHit2), .FwdData2(FwdData2),
    .Count(Count)
  );

  always #5 Clk = ~Clk;

  // Register file model plus a tally of writes to the registers discarded by reset.
  logic [31:0] rf [32];
  int          n_disc = 0;
  always @(posedge Clk) begin
    if (Reset) begin
      for (int k = 0; k < 32; k++) rf[k] <= '0;
    end else if (RegWrite) begin
      rf[WriteRegister] <= WriteData;
      if (WriteRegister >= 5'd8 && WriteRegister <= 5'd10) n_disc <= n_disc + 1;
    end
  end

  typedef struct {
    logic        v;
    logic [4:0]  ra;
    logic [31:0] rd;
    logic        hold;
    logic [4:0]  l1, l2;
    logic        rdy, rw;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [2:0]  cnt;
    logic        h1;
    logic [31:0] d1;
    logic        h2;
    logic [31:0] d2;
    logic [4:0]  rfa;
    logic [31:0] rfd;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cur      = -1;

  task automatic add(input logic v, input int ra, input int rd, input logic hold,
                     input int l1, input int l2, input logic rdy, input logic rw,
                     input int wr, input int wd, input int cnt,
                     input logic h1, input int d1, input logic h2, input int d2,
                     input int rfa, input int rfd);
    vec_t t;
    t.v = v; t.ra = 5'(ra); t.rd = 32'(rd); t.hold = hold;
    t.l1 = 5'(l1); t.l2 = 5'(l2); t.rdy = rdy; t.rw = rw;
    t.wr = 5'(wr); t.wd = 32'(wd); t.cnt = 3'(cnt);
    t.h1 = h1; t.d1 = 32'(d1); t.h2 = h2; t.d2 = 32'(d2);
    t.rfa = 5'(rfa); t.rfd = 32'(rfd);
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %0d, expected %0d", name, cur, act, exp);
    end
  endtask

  initial begin
    // v ra rd hold | l1 l2 | rdy rw wr wd cnt | h1 d1 h2 d2 | rfa rfd
    add(1,2,42,0,   2,0, 1,0,0,0,0,   0,0,0,0,    2,0);
    add(0,0,0,0,    2,0, 1,1,2,42,1,  1,42,0,0,   2,0);
    add(0,0,0,0,    2,0, 1,0,0,0,0,   0,0,0,0,    2,42);
    add(1,3,7,1,    3,4, 1,0,0,0,0,   0,0,0,0,    0,0);
    add(1,3,9,1,    3,4, 1,0,3,7,1,   1,7,0,0,    0,0);
    add(1,4,5,1,    3,4, 1,0,3,7,2,   1,9,0,0,    0,0);
    add(0,0,0,1,    3,4, 1,0,3,7,3,   1,9,1,5,    0,0);
    add(0,0,0,1,    6,4, 1,0,3,7,3,   0,0,1,5,    0,0);
    add(0,0,0,0,    3,4, 1,1,3,7,3,   1,9,1,5,    3,0);
    add(0,0,0,0,    3,4, 1,1,3,9,2,   1,9,1,5,    3,7);
    add(0,0,0,0,    3,4, 1,1,4,5,1,   0,0,1,5,    3,9);
    add(0,0,0,0,    3,4, 1,0,0,0,0,   0,0,0,0,    4,5);
    add(1,1,11,1,   0,0, 1,0,0,0,0,   0,0,0,0,    0,0);
    add(1,2,22,1,   0,0, 1,0,1,11,1,  0,0,0,0,    0,0);
    add(1,3,33,1,   1,2, 1,0,1,11,2,  1,11,1,22,  0,0);
    add(1,4,44,1,   0,0, 1,0,1,11,3,  0,0,0,0,    0,0);
    add(1,5,55,1,   5,4, 0,0,1,11,4,  0,0,1,44,   0,0);
    add(1,5,55,0,   5,4, 0,1,1,11,4,  0,0,1,44,   0,0);
    add(0,0,0,0,    5,1, 1,1,2,22,3,  0,0,0,0,    1,11);
    add(0,0,0,0,    5,0, 1,1,3,33,2,  0,0,0,0,    2,22);
    add(0,0,0,0,    5,0, 1,1,4,44,1,  0,0,0,0,    3,33);
    add(0,0,0,0,    5,0, 1,0,0,0,0,   0,0,0,0,    4,44);
    add(1,0,123,0,  0,0, 1,0,0,0,0,   0,0,0,0,    0,0);
    add(0,0,0,0,    0,0, 1,0,0,0,0,   0,0,0,0,    0,0);
    add(1,5,50,1,   0,0, 1,0,0,0,0,   0,0,0,0,    0,0);
    add(1,6,60,1,   5,0, 1,0,5,50,1,  1,50,0,0,   0,0);
    add(1,7,70,0,   7,5, 1,1,5,50,2,  0,0,1,50,   0,0);
    add(0,0,0,0,    7,6, 1,1,6,60,2,  1,70,1,60,  5,50);
    add(0,0,0,0,    7,0, 1,1,7,70,1,  1,70,0,0,   6,60);
    add(0,0,0,0,    7,0, 1,0,0,0,0,   0,0,0,0,    7,70);

    Reset = 1'b1; Hold = 1'b0; InValid = 1'b1; InRegister = 5'd1; InData = 32'd1;
    LookupRegister1 = 5'd1; LookupRegister2 = 5'd0;
    @(negedge Clk); #1;
    chk("reset_inready", 32'(InReady), 32'd0);
    chk("reset_regwrite", 32'(RegWrite), 32'd0);
    @(negedge Clk); #1;
    chk("reset_count", 32'(Count), 32'd0);
    chk("reset_fwdhit1", 32'(FwdHit1), 32'd0);

    Reset = 1'b0; InValid = 1'b0;
    foreach (vecs[n]) begin
      @(negedge Clk);
      cur             = n;
      InValid         = vecs[n].v;
      InRegister      = vecs[n].ra;
      InData          = vecs[n].rd;
      Hold            = vecs[n].hold;
      LookupRegister1 = vecs[n].l1;
      LookupRegister2 = vecs[n].l2;
      #1;
      chk("inready",   32'(InReady),       32'(vecs[n].rdy));
      chk("regwrite",  32'(RegWrite),      32'(vecs[n].rw));
      chk("writereg",  32'(WriteRegister), 32'(vecs[n].wr));
      chk("writedata", WriteData,          vecs[n].wd);
      chk("count",     32'(Count),         32'(vecs[n].cnt));
      chk("fwdhit1",   32'(FwdHit1),       32'(vecs[n].h1));
      chk("fwddata1",  FwdData1,           vecs[n].d1);
      chk("fwdhit2",   32'(FwdHit2),       32'(vecs[n].h2));
      chk("fwddata2",  FwdData2,           vecs[n].d2);
      chk("regfile",   rf[vecs[n].rfa],    vecs[n].rfd);
    end

    cur = 100;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      Hold = 1'b1; InValid = 1'b1; InRegister = 5'(8 + k); InData = 32'(80 + 10 * k);
    end
    @(negedge Clk);
    InValid = 1'b0; #1;
    chk("pend_count", 32'(Count), 32'd3);
    Reset = 1'b1; Hold = 1'b0; LookupRegister1 = 5'd8; LookupRegister2 = 5'd9; #1;
    chk("rst_regwrite", 32'(RegWrite), 32'd0);
    chk("rst_inready", 32'(InReady), 32'd0);
    chk("rst_fwdhit1", 32'(FwdHit1), 32'd0);
    chk("rst_fwdhit2", 32'(FwdHit2), 32'd0);
    @(negedge Clk);
    Reset = 1'b0; #1;
    chk("post_count", 32'(Count), 32'd0);
    chk("post_fwdhit1", 32'(FwdHit1), 32'd0);
    chk("post_fwdhit2", 32'(FwdHit2), 32'd0);
    chk("post_regwrite", 32'(RegWrite), 32'd0);
    repeat (5) @(negedge Clk);
    chk("discarded_writes", 32'(n_disc), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_buffer.md
Name: regfile_write_buffer

Overview:
Write-side feeder for the 32x32 register file. It accepts register write requests through a valid/ready handshake and buffers them in an in-order FIFO. It drives the register file's single write port (WriteRegister/WriteData/RegWrite) one entry per cycle unless held. It also provides two forwarding lookups, so readers can see data that is still queued and not yet committed to the register file.

Parameters:
DEPTH, 4, number of buffered write entries (power of 2, >=2)
DATA_WIDTH, 32, width of write data
ADDR_WIDTH, 5, width of register address

Ports:
Clk  input  1  clock, all state updates on posedge
Reset  input  1  synchronous, active-high reset
InValid  input  1  write request present
InReady  output  1  buffer can accept a request this cycle
InRegister  input  ADDR_WIDTH  destination register of request
InData  input  DATA_WIDTH  data of request
Hold  input  1  high = do not drain to register file this cycle
WriteRegister  output  ADDR_WIDTH  to regfile WriteRegister
WriteData  output  DATA_WIDTH  to regfile WriteData
RegWrite  output  1  to regfile RegWrite
LookupRegister1  input  ADDR_WIDTH  forwarding query address 1
LookupRegister2  input  ADDR_WIDTH  forwarding query address 2
FwdHit1  output  1  queued write to LookupRegister1 exists
FwdData1  output  DATA_WIDTH  youngest queued data for LookupRegister1
FwdHit2  output  1  same, query 2
FwdData2  output  DATA_WIDTH  same, query 2
Count  output  log2(DEPTH)+1  number of stored entries

Behaviour:
- Storage: circular FIFO with head/tail pointers that wrap modulo DEPTH, plus an occupancy counter. Full = Count==DEPTH. Empty = Count==0.
- Reset (sync, at posedge with Reset=1):
  - Count, pointers and entry valid bits go to 0. All pending entries are discarded.
  - While Reset is high: RegWrite=0, InReady=0, FwdHit1/2=0, no push or pop.
- InReady = !Full && !Reset. It does not depend on Hold.
- Push: occurs at posedge when InValid && InReady.
  - InRegister==0: the handshake completes but nothing is stored (register 0 is hardwired). Count is unaffected by the push.
- Drain: RegWrite = !Empty && !Hold && !Reset, combinational from state and Hold.
  - WriteRegister/WriteData = head entry when !Empty, else 0.
  - At a posedge with RegWrite=1 the regfile commits the entry and the head pops in the same edge. Latency from push to RegWrite is 1 cycle minimum.
- Push and pop in the same edge: Count unchanged, FIFO order preserved. This is legal at any non-full count.
- Full with Hold=0: a pop occurs but InReady is still 0 that cycle. No push while full.
- Hold only blocks draining. Pushes continue until full.
- Forwarding is combinational over stored entries only. A request being pushed in the current cycle is not visible.
  - The youngest matching entry wins.
  - Lookup of register 0 never hits.
  - On a miss, FwdHit=0 and FwdData=0.
  - The head entry being popped this cycle still reports a hit (the regfile is not yet updated).
- No underflow/overflow state exists: a push is ignored when InReady=0, and a pop is impossible when empty.

Test Plan:
- Reset, then push (r2,42) with Hold=0 -> next cycle RegWrite=1, WriteRegister=2, WriteData=42, Count=1; after that edge Count=0, RegWrite=0, and a regfile read of r2 returns 42.
- Hold=1; push (r3,7), (r3,9), (r4,5) -> Count=3. Lookup1=3 gives FwdHit1=1, FwdData1=9. Lookup2=4 gives FwdHit2=1, FwdData2=5. Lookup 6 gives hit=0, data=0.
- Hold=1; push 4 entries (r1..r4 = 11,22,33,44) -> Count=4, InReady=0, and a fifth push (r5,55) is not stored. Release Hold -> RegWrite high for 4 consecutive cycles with addresses 1,2,3,4 in order, then Count=0.
- Push (r0,123) -> InReady=1 and the handshake completes, Count stays 0, RegWrite stays 0, Lookup 0 gives FwdHit=0.
- Count=2 with Hold=0, push (r7,70) in the same cycle as a pop -> Count stays 2; r7 is written to the regfile 2 cycles later, after the older entry.
- 3 entries pending with Hold=1; assert Reset for 1 cycle with Hold=0 -> RegWrite=0 during reset; afterwards Count=0, FwdHit1/2=0, and no write is ever issued for the discarded entries.
